// File: rtl/forwarding_hazard_unit_pkg.sv
// Shared encodings for the Execute-stage forwarding interface and the
// load-use stall sequencer.
package forwarding_hazard_unit_pkg;

   localparam logic [1:0] MUX_OUT = 2'b00;
   localparam logic [1:0] FWD_WB  = 2'b01;
   localparam logic [1:0] FWD_EM  = 2'b10;

   localparam int CNT_W = 2;

   typedef enum logic {
      ST_IDLE  = 1'b0,
      ST_STALL = 1'b1
   } hz_state_e;

   // The newest producer wins when both EX/MEM and MEM/WB match.
   function automatic logic [1:0] fwd_pick(input logic em_hit, input logic wb_hit);
      if (em_hit) begin
         return FWD_EM;
      end else if (wb_hit) begin
         return FWD_WB;
      end
      return MUX_OUT;
   endfunction

endpackage

// File: rtl/forwarding_hazard_unit_fwd_compare.sv
// Priority forwarding select for a single Execute operand, comparing the
// operand address against the EX/MEM and MEM/WB shadow write info.
module fwd_compare #(
   parameter int REG_AW = 3
) (
   input  logic              reads,
   input  logic [REG_AW-1:0] addr,
   input  logic              em_valid,
   input  logic              em_writes,
   input  logic              em_mem_read,
   input  logic [REG_AW-1:0] em_wr_addr,
   input  logic              wb_valid,
   input  logic              wb_writes,
   input  logic [REG_AW-1:0] wb_wr_addr,
   output logic [1:0]        sel
);
   import forwarding_hazard_unit_pkg::*;

   logic em_hit;
   logic wb_hit;

   // A load in EX/MEM has no data yet, so it can never feed the ALU path.
   always_comb begin
      em_hit = reads & em_valid & em_writes & !em_mem_read & (em_wr_addr == addr);
      wb_hit = reads & wb_valid & wb_writes & (wb_wr_addr == addr);
      sel    = fwd_pick(em_hit, wb_hit);
   end

endmodule

// File: rtl/forwarding_hazard_unit.sv
// Forwarding select and load-use hazard control beside a 5-stage pipeline.
// Shadows the ID/EX, EX/MEM and MEM/WB register-write info.
module forwarding_hazard_unit #(
   parameter int REG_AW           = 3,
   parameter int LOAD_USE_BUBBLES = 1
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              dec_valid,
   input  logic [REG_AW-1:0] dec_rsrc,
   input  logic [REG_AW-1:0] dec_rdst,
   input  logic              dec_reads_src,
   input  logic              dec_reads_dst,
   input  logic              dec_writes_reg,
   input  logic [REG_AW-1:0] dec_wr_addr,
   input  logic              dec_mem_read,
   input  logic              flush,
   input  logic              mem_busy,
   output logic [1:0]        FU_Src_Sel,
   output logic [1:0]        FU_Dst_Sel,
   output logic              stall_fd,
   output logic              bubble_ex
);
   import forwarding_hazard_unit_pkg::*;

   typedef struct packed {
      logic              valid;
      logic              reads_src;
      logic              reads_dst;
      logic [REG_AW-1:0] rsrc;
      logic [REG_AW-1:0] rdst;
      logic              writes;
      logic [REG_AW-1:0] wr_addr;
      logic              mem_read;
   } entry_t;

   entry_t     dec_e;
   entry_t     idex_q,  idex_d;
   entry_t     exmem_q, exmem_d;
   entry_t     memwb_q, memwb_d;
   hz_state_e  state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;

   logic       hazard;
   logic       stall_req;
   logic [1:0] src_sel;
   logic [1:0] dst_sel;
   logic       unused_memwb;

   assign unused_memwb = ^{memwb_q.reads_src, memwb_q.reads_dst, memwb_q.rsrc,
                           memwb_q.rdst, memwb_q.mem_read};

   always_comb begin
      dec_e           = '0;
      dec_e.valid     = dec_valid;
      dec_e.reads_src = dec_reads_src;
      dec_e.reads_dst = dec_reads_dst;
      dec_e.rsrc      = dec_rsrc;
      dec_e.rdst      = dec_rdst;
      dec_e.writes    = dec_writes_reg;
      dec_e.wr_addr   = dec_wr_addr;
      dec_e.mem_read  = dec_mem_read;
   end

   // Only the instruction already in ID/EX is compared; decode's own
   // destination never counts against its own sources.
   always_comb begin
      hazard = dec_valid & idex_q.valid & idex_q.mem_read & idex_q.writes &
               ((dec_reads_src & (dec_rsrc == idex_q.wr_addr)) |
                (dec_reads_dst & (dec_rdst == idex_q.wr_addr)));
      stall_req = !flush & ((state_q == ST_STALL) | hazard);
   end

   always_comb begin
      idex_d  = idex_q;
      exmem_d = exmem_q;
      memwb_d = memwb_q;
      state_d = state_q;
      cnt_d   = cnt_q;
      if (!mem_busy) begin
         memwb_d = exmem_q;
         exmem_d = idex_q;
         idex_d  = stall_req ? entry_t'('0) : dec_e;
         case (state_q)
            ST_IDLE: begin
               if (hazard && !flush && (LOAD_USE_BUBBLES > 1)) begin
                  state_d = ST_STALL;
                  cnt_d   = CNT_W'(LOAD_USE_BUBBLES - 1);
               end
            end
            ST_STALL: begin
               if (cnt_q <= CNT_W'(1)) begin
                  state_d = ST_IDLE;
                  cnt_d   = '0;
               end else begin
                  cnt_d = cnt_q - CNT_W'(1);
               end
            end
            default: begin
               state_d = ST_IDLE;
               cnt_d   = '0;
            end
         endcase
      end
      // A taken branch kills the ID/EX entry and any pending stall even
      // while the pipeline is frozen.
      if (flush) begin
         idex_d  = '0;
         state_d = ST_IDLE;
         cnt_d   = '0;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         idex_q  <= '0;
         exmem_q <= '0;
         memwb_q <= '0;
         state_q <= ST_IDLE;
         cnt_q   <= '0;
      end else begin
         idex_q  <= idex_d;
         exmem_q <= exmem_d;
         memwb_q <= memwb_d;
         state_q <= state_d;
         cnt_q   <= cnt_d;
      end
   end

   fwd_compare #(.REG_AW(REG_AW)) u_cmp_src (
      .reads       (idex_q.reads_src),
      .addr        (idex_q.rsrc),
      .em_valid    (exmem_q.valid),
      .em_writes   (exmem_q.writes),
      .em_mem_read (exmem_q.mem_read),
      .em_wr_addr  (exmem_q.wr_addr),
      .wb_valid    (memwb_q.valid),
      .wb_writes   (memwb_q.writes),
      .wb_wr_addr  (memwb_q.wr_addr),
      .sel         (src_sel)
   );

   fwd_compare #(.REG_AW(REG_AW)) u_cmp_dst (
      .reads       (idex_q.reads_dst),
      .addr        (idex_q.rdst),
      .em_valid    (exmem_q.valid),
      .em_writes   (exmem_q.writes),
      .em_mem_read (exmem_q.mem_read),
      .em_wr_addr  (exmem_q.wr_addr),
      .wb_valid    (memwb_q.valid),
      .wb_writes   (memwb_q.writes),
      .wb_wr_addr  (memwb_q.wr_addr),
      .sel         (dst_sel)
   );

   // Outputs are quiet in any cycle where reset is being sampled.
   always_comb begin
      FU_Src_Sel = rst ? MUX_OUT : src_sel;
      FU_Dst_Sel = rst ? MUX_OUT : dst_sel;
      stall_fd   = !rst & stall_req;
      bubble_ex  = !rst & stall_req;
   end

endmodule

// File: tb/tb_forwarding_hazard_unit.sv
// Scenario bench for forwarding_hazard_unit: each cycle's expected
// {FU_Src_Sel, FU_Dst_Sel, stall_fd, bubble_ex} goes through exp_q.
module tb_forwarding_hazard_unit;
   localparam int AW = 3;

   typedef struct packed {
      logic          rst;
      logic          v;
      logic          rs;
      logic [AW-1:0] src;
      logic          rd;
      logic [AW-1:0] dst;
      logic          wr;
      logic [AW-1:0] wa;
      logic          mr;
      logic          fl;
      logic          busy;
   } stim_t;

   logic          clk = 1'b0;
   logic          rst;
   logic          dec_valid;
   logic [AW-1:0] dec_rsrc;
   logic [AW-1:0] dec_rdst;
   logic          dec_reads_src;
   logic          dec_reads_dst;
   logic          dec_writes_reg;
   logic [AW-1:0] dec_wr_addr;
   logic          dec_mem_read;
   logic          flush;
   logic          mem_busy;
   logic [1:0]    FU_Src_Sel;
   logic [1:0]    FU_Dst_Sel;
   logic          stall_fd;
   logic          bubble_ex;

   logic [5:0] exp_q[$];
   int n_cmp  = 0;
   int n_fail = 0;

   always #5 clk = ~clk;

   forwarding_hazard_unit dut (
      .clk            (clk),
      .rst            (rst),
      .dec_valid      (dec_valid),
      .dec_rsrc       (dec_rsrc),
      .dec_rdst       (dec_rdst),
      .dec_reads_src  (dec_reads_src),
      .dec_reads_dst  (dec_reads_dst),
      .dec_writes_reg (dec_writes_reg),
      .dec_wr_addr    (dec_wr_addr),
      .dec_mem_read   (dec_mem_read),
      .flush          (flush),
      .mem_busy       (mem_busy),
      .FU_Src_Sel     (FU_Src_Sel),
      .FU_Dst_Sel     (FU_Dst_Sel),
      .stall_fd       (stall_fd),
      .bubble_ex      (bubble_ex)
   );

   function automatic stim_t mk(input logic v, input logic rs, input logic [AW-1:0] src,
                                input logic rd, input logic [AW-1:0] dst, input logic wr,
                                input logic [AW-1:0] wa, input logic mr);
      stim_t s;
      s = '{rst: 1'b0, v: v, rs: rs, src: src, rd: rd, dst: dst, wr: wr, wa: wa,
            mr: mr, fl: 1'b0, busy: 1'b0};
      return s;
   endfunction

   function automatic stim_t nop();
      return mk(1'b0, 1'b0, 3'd0, 1'b0, 3'd0, 1'b0, 3'd0, 1'b0);
   endfunction

   task automatic apply(input stim_t s);
      @(negedge clk);
      rst            = s.rst;
      dec_valid      = s.v;
      dec_reads_src  = s.rs;
      dec_rsrc       = s.src;
      dec_reads_dst  = s.rd;
      dec_rdst       = s.dst;
      dec_writes_reg = s.wr;
      dec_wr_addr    = s.wa;
      dec_mem_read   = s.mr;
      flush          = s.fl;
      mem_busy       = s.busy;
   endtask

   task automatic drain();
      repeat (3) apply(nop());
   endtask

   task automatic test_reset();
      stim_t s[5];
      logic [5:0] x[5];
      logic [5:0] obs, e;
      for (int i = 0; i < 2; i++) begin
         s[i] = mk(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)),
                   1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)), 1'($urandom_range(0, 1)),
                   3'($urandom_range(0, 7)), 1'($urandom_range(0, 1)));
         s[i].rst = 1'b1;
      end
      for (int i = 2; i < 5; i++) s[i] = nop();
      x = '{6'b000000, 6'b000000, 6'b000000, 6'b000000, 6'b000000};
      for (int i = 0; i < 5; i++) begin
         apply(s[i]);
         exp_q.push_back(x[i]);
         #2;
         obs = {FU_Src_Sel, FU_Dst_Sel, stall_fd, bubble_ex};
         e = exp_q.pop_front();
         n_cmp++;
         if (obs !== e) begin
            n_fail++;
            $display("FAIL reset[%0d]: got %b want %b", i, obs, e);
         end
      end
   endtask

   task automatic test_alu_forward();
      stim_t s[5];
      logic [5:0] x[5];
      logic [5:0] obs, e;
      drain();
      s = '{mk(1, 0, 3'd0, 0, 3'd0, 1, 3'd1, 0),   // ADD R1
            mk(1, 1, 3'd1, 0, 3'd0, 1, 3'd5, 0),   // SUB reads R1
            mk(1, 1, 3'd1, 1, 3'd1, 1, 3'd6, 0),   // OR reads R1 twice
            nop(), nop()};
      x = '{6'b000000, 6'b000000, 6'b100000, 6'b010100, 6'b000000};
      for (int i = 0; i < 5; i++) begin
         apply(s[i]);
         exp_q.push_back(x[i]);
         #2;
         obs = {FU_Src_Sel, FU_Dst_Sel, stall_fd, bubble_ex};
         e = exp_q.pop_front();
         n_cmp++;
         if (obs !== e) begin
            n_fail++;
            $display("FAIL alu_forward[%0d]: got %b want %b", i, obs, e);
         end
      end
   endtask

   task automatic test_load_use();
      stim_t s[4];
      logic [5:0] x[4];
      logic [5:0] obs, e;
      drain();
      s = '{mk(1, 0, 3'd0, 0, 3'd0, 1, 3'd2, 1),   // LDD R2
            mk(1, 0, 3'd0, 1, 3'd2, 1, 3'd6, 0),   // ADD reads R2 as dst
            mk(1, 0, 3'd0, 1, 3'd2, 1, 3'd6, 0),   // held in decode
            nop()};
      x = '{6'b000000, 6'b000011, 6'b000000, 6'b000100};
      for (int i = 0; i < 4; i++) begin
         apply(s[i]);
         exp_q.push_back(x[i]);
         #2;
         obs = {FU_Src_Sel, FU_Dst_Sel, stall_fd, bubble_ex};
         e = exp_q.pop_front();
         n_cmp++;
         if (obs !== e) begin
            n_fail++;
            $display("FAIL load_use[%0d]: got %b want %b", i, obs, e);
         end
      end
   endtask

   task automatic test_load_use_busy();
      stim_t s[8];
      logic [5:0] x[8];
      logic [5:0] obs, e;
      drain();
      s[0] = mk(1, 0, 3'd0, 0, 3'd0, 1, 3'd2, 1);
      for (int i = 1; i < 6; i++) s[i] = mk(1, 0, 3'd0, 1, 3'd2, 1, 3'd6, 0);
      for (int i = 1; i < 4; i++) s[i].busy = 1'b1;
      s[6] = nop();
      s[7] = nop();
      x = '{6'b000000, 6'b000011, 6'b000011, 6'b000011, 6'b000011,
            6'b000000, 6'b000100, 6'b000000};
      for (int i = 0; i < 8; i++) begin
         apply(s[i]);
         exp_q.push_back(x[i]);
         #2;
         obs = {FU_Src_Sel, FU_Dst_Sel, stall_fd, bubble_ex};
         e = exp_q.pop_front();
         n_cmp++;
         if (obs !== e) begin
            n_fail++;
            $display("FAIL load_use_busy[%0d]: got %b want %b", i, obs, e);
         end
      end
   endtask

   task automatic test_flush();
      stim_t s[4];
      logic [5:0] x[4];
      logic [5:0] obs, e;
      drain();
      s = '{mk(1, 0, 3'd0, 0, 3'd0, 1, 3'd2, 1),   // LDD R2
            mk(1, 1, 3'd2, 0, 3'd0, 1, 3'd6, 0),   // user of R2, flushed
            mk(1, 1, 3'd2, 0, 3'd0, 0, 3'd0, 0),   // branch target reads R2
            nop()};
      s[1].fl = 1'b1;
      x = '{6'b000000, 6'b000000, 6'b000000, 6'b010000};
      for (int i = 0; i < 4; i++) begin
         apply(s[i]);
         exp_q.push_back(x[i]);
         #2;
         obs = {FU_Src_Sel, FU_Dst_Sel, stall_fd, bubble_ex};
         e = exp_q.pop_front();
         n_cmp++;
         if (obs !== e) begin
            n_fail++;
            $display("FAIL flush[%0d]: got %b want %b", i, obs, e);
         end
      end
   endtask

   // Second half decodes the reader with dec_valid low so no stall separates
   // it from the load, leaving a load in EX/MEM and an ALU op in MEM/WB.
   task automatic test_priority();
      stim_t s[8];
      logic [5:0] x[8];
      logic [5:0] obs, e;
      drain();
      s = '{mk(1, 0, 3'd0, 0, 3'd0, 1, 3'd3, 0),
            mk(1, 0, 3'd0, 0, 3'd0, 1, 3'd3, 0),
            mk(1, 1, 3'd3, 0, 3'd0, 0, 3'd0, 0),
            nop(),
            mk(1, 0, 3'd0, 0, 3'd0, 1, 3'd3, 0),
            mk(1, 0, 3'd0, 0, 3'd0, 1, 3'd3, 1),
            mk(0, 1, 3'd3, 0, 3'd0, 0, 3'd0, 0),
            nop()};
      x = '{6'b000000, 6'b000000, 6'b000000, 6'b100000,
            6'b000000, 6'b000000, 6'b000000, 6'b010000};
      for (int i = 0; i < 8; i++) begin
         apply(s[i]);
         exp_q.push_back(x[i]);
         #2;
         obs = {FU_Src_Sel, FU_Dst_Sel, stall_fd, bubble_ex};
         e = exp_q.pop_front();
         n_cmp++;
         if (obs !== e) begin
            n_fail++;
            $display("FAIL priority[%0d]: got %b want %b", i, obs, e);
         end
      end
   endtask

   task automatic test_reset_mid_stall();
      stim_t s[5];
      logic [5:0] x[5];
      logic [5:0] obs, e;
      drain();
      s[0] = mk(1, 0, 3'd0, 0, 3'd0, 1, 3'd2, 1);
      for (int i = 1; i < 4; i++) s[i] = mk(1, 1, 3'd2, 0, 3'd0, 1, 3'd6, 0);
      s[2].rst = 1'b1;
      s[4] = nop();
      x = '{6'b000000, 6'b000011, 6'b000000, 6'b000000, 6'b000000};
      for (int i = 0; i < 5; i++) begin
         apply(s[i]);
         exp_q.push_back(x[i]);
         #2;
         obs = {FU_Src_Sel, FU_Dst_Sel, stall_fd, bubble_ex};
         e = exp_q.pop_front();
         n_cmp++;
         if (obs !== e) begin
            n_fail++;
            $display("FAIL reset_mid_stall[%0d]: got %b want %b", i, obs, e);
         end
      end
   endtask

   task automatic test_self_dep();
      stim_t s[4];
      logic [5:0] x[4];
      logic [5:0] obs, e;
      drain();
      s = '{mk(1, 0, 3'd0, 0, 3'd0, 1, 3'd5, 1),   // LDD R5
            mk(1, 1, 3'd4, 0, 3'd0, 1, 3'd4, 1),   // LDD R4 <- [R4]
            nop(), nop()};
      x = '{6'b000000, 6'b000000, 6'b000000, 6'b000000};
      for (int i = 0; i < 4; i++) begin
         apply(s[i]);
         exp_q.push_back(x[i]);
         #2;
         obs = {FU_Src_Sel, FU_Dst_Sel, stall_fd, bubble_ex};
         e = exp_q.pop_front();
         n_cmp++;
         if (obs !== e) begin
            n_fail++;
            $display("FAIL self_dep[%0d]: got %b want %b", i, obs, e);
         end
      end
   endtask

   initial begin
      rst            = 1'b1;
      dec_valid      = 1'b0;
      dec_rsrc       = '0;
      dec_rdst       = '0;
      dec_reads_src  = 1'b0;
      dec_reads_dst  = 1'b0;
      dec_writes_reg = 1'b0;
      dec_wr_addr    = '0;
      dec_mem_read   = 1'b0;
      flush          = 1'b0;
      mem_busy       = 1'b0;

      test_reset();
      test_alu_forward();
      test_load_use();
      test_load_use_busy();
      test_flush();
      test_priority();
      test_reset_mid_stall();
      test_self_dep();

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule
